mem_host_bridge: RTL and testbench

- Sits directly downstream of the processor top-level's memory-controller interface (op, io_addr, common_data_bus_out, cv_value in; common_data_bus_in, tx_done, rd_valid out).
- Converts each 512-bit line command into eight 64-bit host-bus beats, in order.
- Also forwards the completion value (cv_value) as a single host write.
- This is the sole path between the processor's memory arbiter and host memory.

---
 rtl/mem_host_pkg.sv | 26 ++
 rtl/line_serdes.sv | 25 ++
 rtl/mem_host_bridge.sv | 116 +++++++++++
 tb/tb_mem_host_bridge.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_host_pkg.sv
// mem_host_pkg: shared types, sizes and beat addressing for the memory host bridge
// Holds the command/state enums, line geometry, the CV target address and beat_addr().
package mem_host_pkg;
  localparam int LINE_SIZE = 512;
  localparam int BEAT_SIZE = 64;
  localparam int NB = LINE_SIZE / BEAT_SIZE;
  localparam int ADDR_W = 32;
  localparam logic [ADDR_W-1:0] CV_ADDR = 32'hFFFF_FFC0;
  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_CV    = 2'b11
  } op_t;
  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_CVW,
    S_DONE,
    S_WAIT_NOP
  } state_t;
  function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] base, input logic [3:0] idx);
    return base + (ADDR_W'(idx) << 3);
  endfunction
endpackage

// File: rtl/line_serdes.sv
// line_serdes: one line register written a beat at a time and read out a beat at a time
// Ports: i_load/i_load_line replace the whole line; i_wr_en/i_wr_idx/i_wr_beat write one beat;
//   i_rd_idx selects o_beat; o_line_nxt is the line value the register takes at the next edge.
module line_serdes
  import mem_host_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_load,
  input  logic [LINE_SIZE-1:0] i_load_line,
  input  logic                 i_wr_en,
  input  logic [2:0]           i_wr_idx,
  input  logic [BEAT_SIZE-1:0] i_wr_beat,
  input  logic [2:0]           i_rd_idx,
  output logic [LINE_SIZE-1:0] o_line_nxt,
  output logic [BEAT_SIZE-1:0] o_beat
);
  logic [LINE_SIZE-1:0] r_line;
  always_comb begin
    o_line_nxt = i_load ? i_load_line : r_line;
    if (!i_load && i_wr_en) o_line_nxt[{i_wr_idx, 6'd0} +: BEAT_SIZE] = i_wr_beat;
  end
  always_ff @(posedge clk) r_line <= rst ? '0 : o_line_nxt;
  assign o_beat = r_line[{i_rd_idx, 6'd0} +: BEAT_SIZE];
endmodule

// File: rtl/mem_host_bridge.sv
// mem_host_bridge: turns 512-bit line commands into eight in-order 64-bit host beats
// Ports: op/io_addr/common_data_bus_out/cv_value take a command (sampled only when idle);
//   common_data_bus_in/rd_valid return a read line, tx_done ends a WRITE or CV;
//   host_req_* is the valid/ready beat request, host_rsp_* the in-order read beats;
//   busy is high outside IDLE, err_spurious is a sticky unexpected-response flag.
module mem_host_bridge
  import mem_host_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           op,
  input  logic [ADDR_W-1:0]    io_addr,
  input  logic [LINE_SIZE-1:0] common_data_bus_out,
  input  logic [BEAT_SIZE-1:0] cv_value,
  output logic [LINE_SIZE-1:0] common_data_bus_in,
  output logic                 rd_valid,
  output logic                 tx_done,
  output logic                 host_req_valid,
  input  logic                 host_req_ready,
  output logic                 host_req_write,
  output logic [ADDR_W-1:0]    host_req_addr,
  output logic [BEAT_SIZE-1:0] host_req_wdata,
  input  logic                 host_rsp_valid,
  input  logic [BEAT_SIZE-1:0] host_rsp_data,
  output logic                 busy,
  output logic                 err_spurious
);
  state_t               r_state;
  logic [ADDR_W-1:0]    r_base;
  logic [3:0]           r_req_cnt;
  logic [3:0]           r_rsp_cnt;
  logic [BEAT_SIZE-1:0] r_cv;
  logic [LINE_SIZE-1:0] r_rd_line;
  logic                 r_rd_valid;
  logic                 r_tx_done;
  logic                 r_err;
  op_t                  w_op;
  logic                 w_issue;
  logic                 w_hs;
  logic                 w_rsp_ok;
  logic                 w_load;
  logic [BEAT_SIZE-1:0] w_beat;
  logic [LINE_SIZE-1:0] w_line_nxt;
  assign w_op = op_t'(op);
  assign w_issue = ((r_state == S_RD || r_state == S_WR) && r_req_cnt < 4'(NB)) || r_state == S_CVW;
  assign w_hs = w_issue && host_req_ready;
  // a response is legitimate only while a read has requests accepted but not yet answered
  assign w_rsp_ok = host_rsp_valid && r_state == S_RD && r_rsp_cnt != r_req_cnt;
  assign w_load = r_state == S_IDLE && w_op == OP_WRITE;
  line_serdes u_serdes (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_line(common_data_bus_out),
    .i_wr_en    (w_rsp_ok),
    .i_wr_idx   (r_rsp_cnt[2:0]),
    .i_wr_beat  (host_rsp_data),
    .i_rd_idx   (r_req_cnt[2:0]),
    .o_line_nxt (w_line_nxt),
    .o_beat     (w_beat)
  );
  assign host_req_valid = w_issue;
  assign host_req_write = r_state == S_WR || r_state == S_CVW;
  assign host_req_addr = r_state == S_CVW ? CV_ADDR : w_issue ? beat_addr(r_base, r_req_cnt) : '0;
  assign host_req_wdata = r_state == S_CVW ? r_cv : r_state == S_WR ? w_beat : '0;
  assign common_data_bus_in = r_rd_line;
  assign rd_valid = r_rd_valid;
  assign tx_done = r_tx_done;
  assign busy = r_state != S_IDLE;
  assign err_spurious = r_err;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_base     <= '0;
      r_req_cnt  <= '0;
      r_rsp_cnt  <= '0;
      r_cv       <= '0;
      r_rd_line  <= '0;
      r_rd_valid <= 1'b0;
      r_tx_done  <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      r_tx_done  <= 1'b0;
      if (host_rsp_valid && !w_rsp_ok) r_err <= 1'b1;
      if (w_hs) r_req_cnt <= r_req_cnt + 4'd1;
      if (w_rsp_ok) r_rsp_cnt <= r_rsp_cnt + 4'd1;
      case (r_state)
        S_IDLE: if (w_op != OP_NOP) begin
          r_base    <= io_addr & ~ADDR_W'(63);
          r_req_cnt <= '0;
          r_rsp_cnt <= '0;
          if (w_op == OP_CV) r_cv <= cv_value;
          r_state   <= w_op == OP_READ ? S_RD : w_op == OP_WRITE ? S_WR : S_CVW;
        end
        S_RD: if (w_rsp_ok && r_rsp_cnt == 4'(NB - 1)) begin
          // the final beat is merged on the way in so the line is complete in the DONE cycle
          r_rd_line  <= w_line_nxt;
          r_rd_valid <= 1'b1;
          r_state    <= S_DONE;
        end
        S_WR: if (w_hs && r_req_cnt == 4'(NB - 1)) begin
          r_tx_done <= 1'b1;
          r_state   <= S_DONE;
        end
        S_CVW: if (w_hs) begin
          r_tx_done <= 1'b1;
          r_state   <= S_DONE;
        end
        S_DONE: r_state <= S_WAIT_NOP;
        S_WAIT_NOP: if (w_op == OP_NOP) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_host_bridge.sv
// tb_mem_host_bridge: transaction-level model check of mem_host_bridge with directed and random commands
module tb_mem_host_bridge;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] op;
  logic [31:0] io_addr;
  logic [511:0] cdb_out, cdb_in;
  logic [63:0] cv_value;
  logic rd_valid, tx_done, host_req_valid, host_req_ready, host_req_write;
  logic [31:0] host_req_addr;
  logic [63:0] host_req_wdata;
  logic host_rsp_valid;
  logic [63:0] host_rsp_data;
  logic busy, err_spurious;
  mem_host_bridge dut (
    .clk(clk), .rst(rst), .op(op), .io_addr(io_addr), .common_data_bus_out(cdb_out),
    .cv_value(cv_value), .common_data_bus_in(cdb_in), .rd_valid(rd_valid), .tx_done(tx_done),
    .host_req_valid(host_req_valid), .host_req_ready(host_req_ready), .host_req_write(host_req_write),
    .host_req_addr(host_req_addr), .host_req_wdata(host_req_wdata), .host_rsp_valid(host_rsp_valid),
    .host_rsp_data(host_rsp_data), .busy(busy), .err_spurious(err_spurious)
  );
  always #5 clk = ~clk;
  typedef struct {logic w; logic [31:0] a; logic [63:0] d;} req_t;
  typedef struct {int due; logic [63:0] d;} rsp_t;
  req_t req_q[$];
  rsp_t rsp_q[$];
  logic [31:0] hs_addr[$];
  logic [63:0] hs_data[$];
  int hs_cyc[$];
  int n_vec = 0, n_err = 0;
  int cyc = 0, cmd_cyc = 0, lat = 3, rdy_mode = 0, last_due = 0;
  int rdv_cyc = -1, tx_cyc = -1, rdv_cnt = 0, tx_cnt = 0, cmd_cnt = 0;
  int outst = 0, ridx = 0, rd_issued = 0, m_done = -1;
  logic pat = 1'b1, inj = 1'b0, m_busy = 1'b0;
  logic e_rdv = 1'b0, e_tx = 1'b0, e_err = 1'b0;
  logic [511:0] e_line = '0, m_line = '0;
  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // host side: ready pattern, in-order read responses, optional unsolicited beat
  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    host_req_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'(cyc % 2) : 1'($urandom % 2);
    if (rsp_q.size() != 0 && rsp_q[0].due <= cyc) begin
      host_rsp_valid = 1'b1;
      host_rsp_data = rsp_q[0].d;
      void'(rsp_q.pop_front());
    end else if (inj) begin
      host_rsp_valid = 1'b1;
      host_rsp_data = {$urandom, $urandom};
      inj = 1'b0;
    end else host_rsp_valid = 1'b0;
  end
  // single compare process: check this cycle, then advance the model for the next one
  always @(negedge clk) begin
    if (rst) begin
      req_q.delete();
      m_busy = 1'b0; m_done = -1; outst = 0; ridx = 0;
      e_rdv = 1'b0; e_tx = 1'b0; e_err = 1'b0; e_line = '0;
    end else begin
      chk("rd_valid", rd_valid, e_rdv);
      chk("tx_done", tx_done, e_tx);
      chk("line_out", cdb_in, e_line);
      chk("err_spurious", err_spurious, e_err);
      chk("busy", busy, m_busy);
      chk("req_valid", host_req_valid, req_q.size() != 0);
      if (host_req_valid && req_q.size() != 0) begin
        chk("req_write", host_req_write, req_q[0].w);
        chk("req_addr", host_req_addr, req_q[0].a);
        if (req_q[0].w) chk("req_wdata", host_req_wdata, req_q[0].d);
      end
      if (rd_valid) begin rdv_cnt++; rdv_cyc = cyc; end
      if (tx_done) begin tx_cnt++; tx_cyc = cyc; end
      e_rdv = 1'b0;
      e_tx = 1'b0;
      if (host_rsp_valid) begin
        if (outst > 0) begin
          m_line[ridx*64 +: 64] = host_rsp_data;
          ridx++;
          outst--;
          if (ridx == 8) begin e_line = m_line; e_rdv = 1'b1; m_done = cyc + 1; end
        end else e_err = 1'b1;
      end
      if (host_req_valid && host_req_ready && req_q.size() != 0) begin
        hs_addr.push_back(host_req_addr);
        hs_data.push_back(host_req_wdata);
        hs_cyc.push_back(cyc);
        if (!req_q[0].w) begin
          int due;
          due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
          rsp_q.push_back('{due, pat ? 64'h1111_0000_0000_0000 + 64'(rd_issued) : {$urandom, $urandom}});
          last_due = due;
          rd_issued++;
          outst++;
          void'(req_q.pop_front());
        end else begin
          void'(req_q.pop_front());
          if (req_q.size() == 0) begin e_tx = 1'b1; m_done = cyc + 1; end
        end
      end
      if (!m_busy && op != 2'b00) begin
        logic [31:0] base;
        base = {io_addr[31:6], 6'b0};
        m_busy = 1'b1; m_done = -1; ridx = 0; outst = 0; rd_issued = 0;
        cmd_cnt++;
        if (op == 2'b11) req_q.push_back('{1'b1, 32'hFFFF_FFC0, cv_value});
        else for (int i = 0; i < 8; i++)
          req_q.push_back('{op == 2'b10, base + 32'(8 * i), op == 2'b10 ? cdb_out[64*i +: 64] : 64'd0});
      end else if (m_busy && m_done >= 0 && cyc > m_done && op == 2'b00) m_busy = 1'b0;
    end
  end
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic cmd(input logic [1:0] o, input logic [31:0] a, input logic [511:0] l, input logic [63:0] v, input int hold);
    op = o; io_addr = a; cdb_out = l; cv_value = v; cmd_cyc = cyc;
    for (int i = 0; i < hold; i++) begin
      tick(1);
      io_addr = $urandom;
      cdb_out = {16{$urandom}};
      cv_value = {$urandom, $urandom};
    end
    op = 2'b00;
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 400 && (m_busy || busy); i++) tick(1);
    chk("idle_timeout", m_busy || busy, 1'b0);
  endtask
  task automatic clear_log();
    hs_addr.delete(); hs_data.delete(); hs_cyc.delete();
  endtask
  function automatic logic [511:0] rnd_line();
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[32*i +: 32] = $urandom;
    return l;
  endfunction
  initial begin
    logic [511:0] wl;
    int c0, r0, t0, n_cyc;
    op = 2'b00; io_addr = '0; cdb_out = '0; cv_value = '0;
    host_req_ready = 1'b1; host_rsp_valid = 1'b0; host_rsp_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick(1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err_spurious, 1'b0);
    chk("rst_line", cdb_in, 512'd0);
    chk("rst_req_valid", host_req_valid, 1'b0);
    clear_log();
    cmd(2'b01, 32'h0000_1040, rnd_line(), 64'd0, 1);
    wait_idle();
    chk("t1_rdv_cycle", rdv_cyc, cmd_cyc + 12);
    chk("t1_nreq", hs_addr.size(), 8);
    chk("t1_addr0", hs_addr[0], 32'h0000_1040);
    chk("t1_addr7", hs_addr[7], 32'h0000_1078);
    chk("t1_beat0", cdb_in[63:0], 64'h1111_0000_0000_0000);
    chk("t1_beat7", cdb_in[511:448], 64'h1111_0000_0000_0007);
    rdy_mode = 1;
    for (int i = 0; i < 8; i++) wl[64*i +: 64] = 64'hA5A5_0000_0000_0000 + 64'(i);
    clear_log();
    t0 = tx_cnt;
    cmd(2'b10, 32'h0000_2000, wl, 64'd0, 1);
    wait_idle();
    chk("t2_tx_once", tx_cnt - t0, 1);
    chk("t2_nreq", hs_addr.size(), 8);
    chk("t2_addr3", hs_addr[3], 32'h0000_2018);
    chk("t2_data5", hs_data[5], 64'hA5A5_0000_0000_0005);
    rdy_mode = 0;
    clear_log();
    cmd(2'b11, 32'h1234_5678, rnd_line(), 64'hDEAD_BEEF_0000_0001, 1);
    wait_idle();
    chk("t3_tx_cycle", tx_cyc, cmd_cyc + 2);
    chk("t3_nreq", hs_addr.size(), 1);
    chk("t3_addr", hs_addr[0], 32'hFFFF_FFC0);
    chk("t3_data", hs_data[0], 64'hDEAD_BEEF_0000_0001);
    lat = 2;
    clear_log();
    c0 = cmd_cnt;
    r0 = rdv_cnt;
    cmd(2'b01, 32'h0000_4000, rnd_line(), 64'd0, 32);
    n_cyc = cyc;
    tick(1);
    cmd(2'b01, 32'h0000_4100, rnd_line(), 64'd0, 1);
    wait_idle();
    chk("t4_ncmd", cmd_cnt - c0, 2);
    chk("t4_nrdv", rdv_cnt - r0, 2);
    chk("t4_nreq", hs_addr.size(), 16);
    chk("t4_start", hs_cyc[8], n_cyc + 2);
    chk("t4_addr8", hs_addr[8], 32'h0000_4100);
    inj = 1'b1;
    tick(4);
    chk("t5_err_set", err_spurious, 1'b1);
    chk("t5_line_kept", cdb_in[511:448], 64'h1111_0000_0000_0007);
    tick(5);
    chk("t5_err_sticky", err_spurious, 1'b1);
    lat = 6;
    pat = 1'b0;
    clear_log();
    r0 = rdv_cnt;
    cmd(2'b01, 32'h0000_3000, rnd_line(), 64'd0, 1);
    for (int i = 0; i < 40 && hs_addr.size() < 4; i++) tick(1);
    chk("t6_four_beats", hs_addr.size() >= 4, 1'b1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(15);
    chk("t6_err_late", err_spurious, 1'b1);
    chk("t6_no_rdv", rdv_cnt - r0, 0);
    t0 = tx_cnt;
    cmd(2'b10, 32'h0000_5000, rnd_line(), 64'd0, 1);
    wait_idle();
    chk("t6_write_done", tx_cnt - t0, 1);
    for (int n = 0; n < 40; n++) begin
      rdy_mode = $urandom_range(0, 2);
      lat = $urandom_range(1, 5);
      if ($urandom_range(0, 5) == 0) inj = 1'b1;
      cmd(2'($urandom_range(1, 3)), $urandom, rnd_line(), {$urandom, $urandom}, $urandom_range(1, 3));
      wait_idle();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1);
  end
endmodule
